reg_cmd_master: RTL and testbench

Command-frame initiator that drives the register file's WrEn/RdEn/Address/WrData port and consumes its RdData/RdData_Valid response. It parses a byte stream from the UART receive path, issues one-cycle write or read strobes, and returns read data as a byte to the UART transmit path through a valid/ready handshake. It sits between the RX data-sync output and the TX FIFO in the system clock domain.

---
 rtl/reg_cmd_pkg.sv | 16 +
 rtl/reg_cmd_master.sv | 128 ++++++++++++
 tb/tb_reg_cmd_master.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_cmd_pkg.sv
// Shared opcode constants and FSM state type for the register command master.
package reg_cmd_pkg;

  localparam logic [7:0] WR_CMD = 8'hAA;
  localparam logic [7:0] RD_CMD = 8'hBB;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_SEND = 3'd5
  } state_e;

endpackage

// File: rtl/reg_cmd_master.sv
// Parses AA/BB command frames from the UART RX byte stream, strobes the register
// file and returns read data (or an error byte on timeout) to the TX path.
module reg_cmd_master
  import reg_cmd_pkg::*;
#(
  parameter int                    ADDRESS_WIDTH  = 4,
  parameter int                    DATA_WIDTH     = 8,
  parameter int                    TIMEOUT_CYCLES = 16,
  parameter logic [DATA_WIDTH-1:0] ERR_BYTE       = 8'hEE
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic                     TX_READY,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDRESS_WIDTH-1:0] Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic [DATA_WIDTH-1:0]    TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     BUSY,
  output logic                     DROP
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  state_e                   r_state;
  state_e                   w_next;
  logic [CNT_W-1:0]         r_cnt;
  logic                     r_wr_en;
  logic                     r_rd_en;
  logic [ADDRESS_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0]    r_wr_data;
  logic [DATA_WIDTH-1:0]    r_tx_data;
  logic                     r_tx_vld;
  logic                     r_busy;
  logic                     r_drop;
  logic                     w_is_wr;
  logic                     w_is_rd;
  logic                     w_timeout;
  logic                     w_discard;

  assign w_is_wr   = (RX_P_DATA == DATA_WIDTH'(WR_CMD));
  assign w_is_rd   = (RX_P_DATA == DATA_WIDTH'(RD_CMD));
  assign w_timeout = (r_cnt == CNT_W'(TIMEOUT_CYCLES));
  assign w_discard = RX_D_VLD && ((r_state == ST_RD_WAIT) || (r_state == ST_TX_SEND));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (RX_D_VLD && w_is_wr)      w_next = ST_WR_ADDR;
        else if (RX_D_VLD && w_is_rd) w_next = ST_RD_ADDR;
      end
      ST_WR_ADDR: if (RX_D_VLD) w_next = ST_WR_DATA;
      ST_WR_DATA: if (RX_D_VLD) w_next = ST_IDLE;
      ST_RD_ADDR: if (RX_D_VLD) w_next = ST_RD_WAIT;
      ST_RD_WAIT: if (RdData_Valid || w_timeout) w_next = ST_TX_SEND;
      ST_TX_SEND: if (TX_READY) w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_addr    <= '0;
      r_wr_data <= '0;
      r_tx_data <= '0;
      r_tx_vld  <= 1'b0;
      r_busy    <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next != ST_IDLE);
      r_wr_en <= 1'b0;
      r_rd_en <= 1'b0;
      r_drop  <= w_discard;
      case (r_state)
        ST_WR_ADDR: if (RX_D_VLD) r_addr <= RX_P_DATA[ADDRESS_WIDTH-1:0];
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            r_wr_data <= RX_P_DATA;
            r_wr_en   <= 1'b1;
          end
        end
        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            r_addr  <= RX_P_DATA[ADDRESS_WIDTH-1:0];
            r_rd_en <= 1'b1;
            r_cnt   <= '0;
          end
        end
        // Counting starts once RdEn has dropped, so the error byte appears
        // TIMEOUT_CYCLES+1 cycles after the strobe ends.
        ST_RD_WAIT: begin
          if (RdData_Valid) begin
            r_tx_data <= RdData;
            r_tx_vld  <= 1'b1;
          end else if (w_timeout) begin
            r_tx_data <= ERR_BYTE;
            r_tx_vld  <= 1'b1;
          end else if (!r_rd_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_TX_SEND: if (TX_READY) r_tx_vld <= 1'b0;
        default: ;
      endcase
    end
  end

  assign WrEn      = r_wr_en;
  assign RdEn      = r_rd_en;
  assign Address   = r_addr;
  assign WrData    = r_wr_data;
  assign TX_P_DATA = r_tx_data;
  assign TX_D_VLD  = r_tx_vld;
  assign BUSY      = r_busy;
  assign DROP      = r_drop;

endmodule

// File: tb/tb_reg_cmd_master.sv
// Bench for reg_cmd_master: vector table, hand-built corner sequences and a
// randomized frame stream checked against a frame-level reference model.
module tb_reg_cmd_master;

  localparam int TMO = 16;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] RX_P_DATA;
  logic       RX_D_VLD;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       TX_READY;
  logic       WrEn, RdEn, TX_D_VLD, BUSY, DROP;
  logic [3:0] Address;
  logic [7:0] WrData, TX_P_DATA;

  reg_cmd_master #(
    .ADDRESS_WIDTH(4), .DATA_WIDTH(8), .TIMEOUT_CYCLES(TMO), .ERR_BYTE(8'hEE)
  ) dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_READY(TX_READY),
    .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
    .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .BUSY(BUSY), .DROP(DROP)
  );

  always #5 CLK = ~CLK;

  // Register file peer: one-cycle read latency, optional silence for timeouts.
  logic [7:0] rf_mem [16];
  logic       rf_resp;
  always @(posedge CLK) begin
    if (!RST) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 8'h00;
      RdData_Valid <= 1'b0;
      RdData       <= 8'h00;
    end else begin
      RdData_Valid <= RdEn && rf_resp;
      RdData       <= rf_mem[Address];
      if (WrEn) rf_mem[Address] <= WrData;
    end
  end

  // Transaction monitor
  logic [11:0] wr_log [$];
  logic [7:0]  tx_log [$];
  int          drop_cnt;
  int          both_cnt;
  always @(negedge CLK) begin
    if (WrEn) wr_log.push_back({Address, WrData});
    if (TX_D_VLD && TX_READY) tx_log.push_back(TX_P_DATA);
    if (DROP) drop_cnt++;
    if (WrEn && RdEn) both_cnt++;
  end

  int         n_assert = 0;
  int         n_fail   = 0;
  logic [7:0] ref_mem [16];

  typedef struct {
    logic       is_rd;
    logic [7:0] addr;
    logic [7:0] data;
    logic [3:0] exp_addr;
    logic [7:0] exp_out;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    tick();
    RX_D_VLD  = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    send_byte(8'hAA);
    send_byte(a);
    send_byte(d);
    check("wr_en", 32'(WrEn), 32'd1);
    check("wr_rden_low", 32'(RdEn), 32'd0);
    check("wr_addr", 32'(Address), 32'(a[3:0]));
    check("wr_data", 32'(WrData), 32'(d));
    ref_mem[a[3:0]] = d;
    tick();
    check("wr_en_one_cycle", 32'(WrEn), 32'd0);
    check("wr_idle", 32'(BUSY), 32'd0);
  endtask

  task automatic wait_tx(input string name, input int limit, output int cyc);
    cyc = 0;
    while (!TX_D_VLD && cyc < limit) begin
      tick();
      cyc++;
    end
    check(name, 32'(TX_D_VLD), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, held, d0, w0, t0, kind;
    logic [7:0] a, d, b;
    logic [7:0] exp_tx [$];
    logic [11:0] exp_wr [$];

    RST = 1'b0; RX_P_DATA = 8'h00; RX_D_VLD = 1'b0;
    TX_READY = 1'b1; rf_resp = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    repeat (3) tick();
    check("reset_outputs", 32'({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, DROP}), 32'd0);
    check("reset_busy", 32'(BUSY), 32'd0);
    RST = 1'b1;
    tick();

    vecs[0] = '{1'b0, 8'h05, 8'h3C, 4'h5, 8'h3C};
    vecs[1] = '{1'b0, 8'h02, 8'h20, 4'h2, 8'h20};
    vecs[2] = '{1'b0, 8'h0F, 8'hA5, 4'hF, 8'hA5};
    vecs[3] = '{1'b0, 8'h13, 8'h77, 4'h3, 8'h77};
    vecs[4] = '{1'b1, 8'h02, 8'h00, 4'h2, 8'h20};
    vecs[5] = '{1'b1, 8'h05, 8'h00, 4'h5, 8'h3C};
    vecs[6] = '{1'b1, 8'h13, 8'h00, 4'h3, 8'h77};
    vecs[7] = '{1'b1, 8'hFF, 8'h00, 4'hF, 8'hA5};
    for (int v = 0; v < 8; v++) begin
      if (!vecs[v].is_rd) begin
        do_write(vecs[v].addr, vecs[v].data);
        check("tbl_wr_addr", 32'(Address), 32'(vecs[v].exp_addr));
      end else begin
        send_byte(8'hBB);
        send_byte(vecs[v].addr);
        check("tbl_rd_en", 32'(RdEn), 32'd1);
        check("tbl_rd_addr", 32'(Address), 32'(vecs[v].exp_addr));
        tick();
        check("tbl_rd_en_one_cycle", 32'(RdEn), 32'd0);
        wait_tx("tbl_rd_wait", 20, cyc);
        check("tbl_rd_latency", 32'(cyc), 32'd1);
        check("tbl_rd_data", 32'(TX_P_DATA), 32'(vecs[v].exp_out));
        tick();
        check("tbl_tx_single", 32'(TX_D_VLD), 32'd0);
        check("tbl_rd_idle", 32'(BUSY), 32'd0);
      end
    end

    // Non-opcode byte in IDLE is silently ignored
    d0 = drop_cnt; w0 = wr_log.size();
    send_byte(8'h11);
    tick();
    check("ign_busy", 32'(BUSY), 32'd0);
    check("ign_no_wr", 32'(wr_log.size()), 32'(w0));
    do_write(8'h03, 8'hFF);
    check("ign_no_drop", 32'(drop_cnt - d0), 32'd0);

    // Silent register file: error byte after the timeout
    rf_resp = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h07);
    check("tmo_rd_en", 32'(RdEn), 32'd1);
    tick();
    wait_tx("tmo_wait", 200, cyc);
    check("tmo_latency", 32'(cyc), 32'(TMO + 1));
    check("tmo_err_byte", 32'(TX_P_DATA), 32'hEE);
    tick();
    check("tmo_idle", 32'(BUSY), 32'd0);
    rf_resp = 1'b1;

    // TX backpressure with a byte arriving during the stall
    do_write(8'h01, 8'h5A);
    TX_READY = 1'b0;
    d0 = drop_cnt;
    send_byte(8'hBB);
    send_byte(8'h01);
    wait_tx("bp_wait", 20, cyc);
    held = 0;
    for (int i = 0; i < 10; i++) begin
      if (TX_D_VLD === 1'b1 && TX_P_DATA === 8'h5A) held++;
      if (i == 1) check("bp_drop_pulse", 32'(DROP), 32'd1);
      RX_P_DATA = 8'h55;
      RX_D_VLD  = (i == 0);
      tick();
    end
    RX_D_VLD = 1'b0;
    check("bp_held_cycles", 32'(held), 32'd10);
    check("bp_drop_count", 32'(drop_cnt - d0), 32'd1);
    check("bp_busy_stall", 32'(BUSY), 32'd1);
    TX_READY = 1'b1;
    tick();
    check("bp_vld_fall", 32'(TX_D_VLD), 32'd0);
    check("bp_idle", 32'(BUSY), 32'd0);

    // Reset in the middle of a write frame
    w0 = wr_log.size();
    send_byte(8'hAA);
    send_byte(8'h04);
    RST = 1'b0;
    #1;
    check("rst_mid_outputs", 32'({WrEn, RdEn, Address, WrData, TX_P_DATA, TX_D_VLD, DROP}), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    tick();
    RST = 1'b1;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'h00;
    tick();
    send_byte(8'h3C);
    repeat (3) tick();
    check("rst_no_wr", 32'(wr_log.size()), 32'(w0));
    check("rst_after_busy", 32'(BUSY), 32'd0);

    // Randomized frame stream against the frame-level model
    w0 = wr_log.size(); t0 = tx_log.size(); d0 = drop_cnt;
    for (int f = 0; f < 40; f++) begin
      kind = $urandom_range(0, 5);
      if (kind == 0) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hAA || b == 8'hBB) b = 8'h5C;
        send_byte(b);
      end else if (kind <= 2) begin
        a = 8'($urandom_range(0, 255));
        d = 8'($urandom_range(0, 255));
        send_byte(8'hAA);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(a);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(d);
        exp_wr.push_back({a[3:0], d});
        ref_mem[a[3:0]] = d;
      end else begin
        a = 8'($urandom_range(0, 255));
        rf_resp = ($urandom_range(0, 3) != 0);
        send_byte(8'hBB);
        repeat ($urandom_range(0, 2)) tick();
        send_byte(a);
        exp_tx.push_back(rf_resp ? ref_mem[a[3:0]] : 8'hEE);
        cyc = 0;
        while (BUSY && cyc < 300) begin
          TX_READY = 1'($urandom_range(0, 1));
          tick();
          cyc++;
        end
        check("rand_rd_done", 32'(BUSY), 32'd0);
        TX_READY = 1'b1;
        rf_resp  = 1'b1;
      end
    end
    repeat (2) tick();
    check("rand_wr_count", 32'(wr_log.size() - w0), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size(); i++)
      if (w0 + i < wr_log.size()) check("rand_wr", 32'(wr_log[w0 + i]), 32'(exp_wr[i]));
    check("rand_tx_count", 32'(tx_log.size() - t0), 32'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      if (t0 + i < tx_log.size()) check("rand_tx", 32'(tx_log[t0 + i]), 32'(exp_tx[i]));
    check("rand_no_drop", 32'(drop_cnt - d0), 32'd0);
    check("strobes_exclusive", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
